// File: rtl/hazard_pkg.sv
// Shared forwarding-select encodings for the hazard scoreboard.
// HAZARD_FWD_EN enables forwarding in hazard_port_chk; when undefined, any pending write stalls.
package hazard_pkg;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  // A result one cycle from writeback sits in MEM/WB; two cycles away it sits in EX/MEM.
  function automatic logic [1:0] fwd_for_remaining(input int unsigned remaining);
    case (remaining)
      1:       return FWD_MEMWB;
      2:       return FWD_EXMEM;
      default: return FWD_RF;
    endcase
  endfunction

endpackage

// File: rtl/hazard_port_chk.sv
// Per-read-port RAW check against the pending-write countdowns.
// Macro HAZARD_FWD_EN selects forwarding; otherwise any pending write raises a stall.
module hazard_port_chk
  import hazard_pkg::*;
#(
  parameter int NREG = 16,
  parameter int LW   = 3,
  localparam int AW  = $clog2(NREG)
) (
  input  logic [AW-1:0]            addr,
  input  logic                     re,
  input  logic [NREG-1:0][LW-1:0]  cnt,
  output logic [1:0]               sel,
  output logic                     raw_stall
);

  logic [LW-1:0] pend;

  assign pend = cnt[addr];

  always_comb begin
    sel       = FWD_RF;
    raw_stall = 1'b0;
    if (re) begin
`ifdef HAZARD_FWD_EN
      if (32'(pend) >= 32'd3) raw_stall = 1'b1;
      else sel = fwd_for_remaining(32'(pend));
`else
      raw_stall = (pend != '0);
`endif
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Register scoreboard: per-register write countdowns, RAW/WAW stall and forwarding select.
// Macro HAZARD_FWD_EN enables EX/MEM and MEM/WB forwarding; default build stalls on any pending write.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREG   = 16,
  parameter int NRD    = 2,
  parameter int MAXLAT = 4,
  localparam int AW    = $clog2(NREG),
  localparam int LW    = $clog2(MAXLAT + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  input  logic                issue_we,
  input  logic [AW-1:0]       issue_rd,
  input  logic [LW-1:0]       issue_lat,
  input  logic [NRD*AW-1:0]   src_addr,
  input  logic [NRD-1:0]      src_re,
  input  logic                flush,
  output logic                stall,
  output logic [2*NRD-1:0]    fwd_sel,
  output logic [15:0]         stall_cycles
);

  localparam logic [LW-1:0] ONE = LW'(1);

  logic [NREG-1:0][LW-1:0] cnt;
  logic [LW-1:0]           lat_eff;
  logic [NRD-1:0]          raw;
  logic                    waw;
  logic                    accept;

  always_comb begin
    lat_eff = issue_lat;
    if (issue_lat == '0) lat_eff = ONE;
    else if (32'(issue_lat) > MAXLAT) lat_eff = LW'(MAXLAT);
  end

  for (genvar i = 0; i < NRD; i++) begin : g_port
    hazard_port_chk #(
      .NREG (NREG),
      .LW   (LW)
    ) u_chk (
      .addr      (src_addr[i*AW +: AW]),
      .re        (src_re[i]),
      .cnt       (cnt),
      .sel       (fwd_sel[2*i +: 2]),
      .raw_stall (raw[i])
    );
  end

  // An older write finishing after this one would clobber the newer value.
  assign waw    = issue_valid & issue_we & (cnt[issue_rd] > lat_eff);
  assign stall  = issue_valid & ((|raw) | waw);
  assign accept = issue_valid & ~stall & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      for (int unsigned r = 0; r < NREG; r++) begin
        if (accept && issue_we && issue_rd == AW'(r)) cnt[r] <= lat_eff;
        else if (cnt[r] != '0) cnt[r] <= cnt[r] - ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cycles <= '0;
    else if (stall && stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter NREG, default 16: number of architectural registers; AW = clog2(NREG).
REQ-002 Parameter NRD, default 2: number of source read ports checked per issue.
REQ-003 Parameter MAXLAT, default 4: maximum result latency in cycles; LW = clog2(MAXLAT+1).
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: asynchronous, active-high reset.
REQ-006 Port issue_valid, input, 1: an instruction is presented in decode.
REQ-007 Port issue_we, input, 1: the presented instruction writes a register.
REQ-008 Port issue_rd, input, AW: destination register.
REQ-009 Port issue_lat, input, LW: cycles until the result reaches the register file (1 = ALU, 2 = load, up to MAXLAT).
REQ-010 Port src_addr, input, NRD*AW: packed source register addresses, port i at bits [i*AW +: AW].
REQ-011 Port src_re, input, NRD: per-port read enable.
REQ-012 Port flush, input, 1: squash the presented instruction.
REQ-013 Port stall, output, 1: hold decode; the issue is not accepted this cycle.
REQ-014 Port fwd_sel, output, 2*NRD: per-port select; 00 register file, 01 EX/MEM, 10 MEM/WB.
REQ-015 Port stall_cycles, output, 16: saturating count of stalled cycles.

Function
REQ-016 Keep one LW-bit countdown cnt[r] per register; cnt = 0 means no write is pending.
REQ-017 Every cycle, decrement each nonzero cnt[r] by 1, including stall cycles.
REQ-018 Accept the issue when issue_valid & ~stall & ~flush; if issue_we is also set, load cnt[issue_rd] = max(issue_lat, 1), overriding the decrement.
REQ-019 Treat issue_lat = 0 as 1; clamp issue_lat > MAXLAT to MAXLAT.
REQ-020 For each port i with src_re[i]: cnt = 0 gives sel 00, cnt = 1 gives sel 10, cnt = 2 gives sel 01, and cnt >= 3 raises a RAW stall with sel 00.
REQ-021 Drive fwd_sel 00 for any port with src_re[i] = 0.
REQ-022 Raise a WAW stall when issue_valid & issue_we and cnt[issue_rd] > clamped issue_lat.
REQ-023 Compute stall combinationally: issue_valid & (any RAW | WAW); flush does not suppress stall.
REQ-024 A flushed issue never modifies cnt; writes already in flight continue to count down.
REQ-025 Compare all read ports against the pre-update cnt, so there is no same-cycle self-forwarding.
REQ-026 Increment stall_cycles on each cycle with stall = 1 and saturate at 16'hFFFF.

Reset
REQ-027 While rst is high, hold all cnt = 0 and stall_cycles = 0, forcing stall = 0 and fwd_sel = 0 for registered inputs.
REQ-028 If rst asserts while writes are pending, drop those writes; no forwarding is reported after rst is released.

Configuration
REQ-029 Macro HAZARD_FWD_EN defined: behaviour is as in REQ-020.
REQ-030 Macro HAZARD_FWD_EN undefined: any cnt != 0 on an enabled port stalls, and fwd_sel is tied to 0.

Structure
REQ-031 Put the fwd_sel encodings (FWD_RF, FWD_EXMEM, FWD_MEMWB) in the shared package hazard_pkg.
REQ-032 Implement one sub-module, hazard_port_chk, instantiated NRD times: it takes an address and the cnt array, and returns sel and raw_stall.

Verification
REQ-033 Issue r3 with lat 1, then read r3 on port 0 the next cycle: sel0 = 10, stall = 0.
REQ-034 Issue r5 with lat 2, then read r5 the next cycle: sel = 01. One cycle later the read gives sel = 10; the cycle after gives sel = 00.
REQ-035 Issue r7 with lat 4, then read r7 immediately: stall for 2 cycles, then sel = 01, and stall_cycles = 2.
REQ-036 Issue r2 with lat 4, then issue r2 with lat 1 the next cycle: WAW stall until cnt[r2] <= 1, then accept.
REQ-037 Assert flush while issuing r9 with lat 3, then read r9: sel = 00, no stall.
REQ-038 Assert rst mid-flight with cnt[r4] = 3, then read r4 after release: sel = 00, stall = 0. With HAZARD_FWD_EN undefined, repeating REQ-033 gives a 1-cycle stall.
